wavelet_fir_bank: RTL and testbench

Multi-channel successor to the single-filter wavelet FIR: one shared sample delay line feeds `NUM_CHAN` filters, each with its own run-time-loadable coefficient set (one wavelet scale per channel). A single time-shared signed multiplier computes all channel sums sequentially after a start pulse, with a busy/valid handshake. It sits between the sample front end and the per-scale output/readout logic.

---
 rtl/wavelet_pkg.sv | 23 ++
 rtl/fir_mac_unit.sv | 38 +++
 rtl/wavelet_fir_bank.sv | 166 ++++++++++++++++
 tb/tb_wavelet_fir_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared types and helpers for the multi-scale wavelet FIR bank.
package wavelet_pkg;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_MAC  = 2'd1,
    FSM_DONE = 2'd2
  } fsm_state_e;

  localparam logic [1:0] ST_IDLE = FSM_IDLE;
  localparam logic [1:0] ST_MAC  = FSM_MAC;
  localparam logic [1:0] ST_DONE = FSM_DONE;

  // Accumulator width that cannot overflow for n products of two b-bit signed values.
  function automatic int unsigned acc_bits(input int unsigned b, input int unsigned n);
    return 2 * b + $clog2(n) + 1;
  endfunction

  function automatic int unsigned sum_slice(input int unsigned chan, input int unsigned w);
    return chan * w;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate slice shared by all filter channels.
module fir_mac_unit
  import wavelet_pkg::*;
#(
  parameter int unsigned BITS     = 8,
  parameter int unsigned ACC_BITS = acc_bits(8, 7)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [BITS-1:0]     coef,
  input  logic signed [BITS-1:0]     sample,
  output logic signed [ACC_BITS-1:0] acc,
  output logic signed [ACC_BITS-1:0] acc_next_c
);

  localparam int unsigned PROD_BITS = 2 * BITS;

  logic signed [PROD_BITS-1:0] prod_c;
  logic signed [ACC_BITS-1:0]  prod_ext_c;

  assign prod_c     = coef * sample;
  assign prod_ext_c = {{(ACC_BITS - PROD_BITS){prod_c[PROD_BITS-1]}}, prod_c};
  assign acc_next_c = acc + prod_ext_c;

  // Clear wins over accumulate so the final tap's sum can be taken from acc_next_c.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next_c;
    end
  end

endmodule

// File: rtl/wavelet_fir_bank.sv
// Shared delay line feeding NUM_CHAN loadable FIR filters, evaluated
// sequentially on one multiplier after a start pulse.
module wavelet_fir_bank
  import wavelet_pkg::*;
#(
  parameter int unsigned BITS_PER_ELEM = 8,
  parameter int unsigned NUM_ELEM      = 7,
  parameter int unsigned NUM_CHAN      = 4,
  parameter int unsigned ACC_BITS      = acc_bits(BITS_PER_ELEM, NUM_ELEM)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [BITS_PER_ELEM-1:0]   i_sample,
  input  logic                              i_sample_valid,
  input  logic                              i_coef_we,
  input  logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] i_coef_chan,
  input  logic [$clog2(NUM_ELEM)-1:0]       i_coef_idx,
  input  logic signed [BITS_PER_ELEM-1:0]   i_coef_data,
  input  logic                              i_start_calc,
  output logic                              o_busy,
  output logic                              o_valid,
  output logic [NUM_CHAN*ACC_BITS-1:0]      o_sum
);

  localparam int unsigned CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int unsigned IDX_W  = $clog2(NUM_ELEM);

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic signed [BITS_PER_ELEM-1:0] taps     [NUM_ELEM];
  logic signed [BITS_PER_ELEM-1:0] taps_nxt [NUM_ELEM];
  logic signed [BITS_PER_ELEM-1:0] snap     [NUM_ELEM];
  logic signed [BITS_PER_ELEM-1:0] coef     [NUM_CHAN][NUM_ELEM];
  logic signed [ACC_BITS-1:0]      stage    [NUM_CHAN];

  logic [CHAN_W-1:0] ch;
  logic [IDX_W-1:0]  idx;

  logic                       last_tap_c;
  logic                       last_chan_c;
  logic                       coef_wr_c;
  logic                       mac_clr_c;
  logic                       mac_en_c;
  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] acc_next_c;

  assign last_tap_c  = (idx == IDX_W'(NUM_ELEM - 1));
  assign last_chan_c = (ch == CHAN_W'(NUM_CHAN - 1));
  assign coef_wr_c   = i_coef_we && (state == ST_IDLE)
                       && (32'(i_coef_chan) < NUM_CHAN)
                       && (32'(i_coef_idx) < NUM_ELEM);

  // Next delay-line contents; the start snapshot uses this so a same-cycle shift is included.
  always_comb begin
    for (int unsigned k = 0; k < NUM_ELEM; k++) begin
      taps_nxt[k] = taps[k];
    end
    if (i_sample_valid) begin
      taps_nxt[0] = i_sample;
      for (int unsigned k = 1; k < NUM_ELEM; k++) begin
        taps_nxt[k] = taps[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mac_clr_c = 1'b0;
    mac_en_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start_calc) begin
          state_nxt = ST_MAC;
          mac_clr_c = 1'b1;
        end
      end
      ST_MAC: begin
        mac_en_c = 1'b1;
        if (last_tap_c) begin
          mac_clr_c = 1'b1;
          if (last_chan_c) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  fir_mac_unit #(
    .BITS     (BITS_PER_ELEM),
    .ACC_BITS (ACC_BITS)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (mac_clr_c),
    .en         (mac_en_c),
    .coef       (coef[ch][idx]),
    .sample     (snap[idx]),
    .acc        (acc),
    .acc_next_c (acc_next_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_ELEM; k++) begin
        taps[k] <= '0;
        snap[k] <= '0;
      end
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
        stage[c] <= '0;
        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
          coef[c][k] <= '0;
        end
      end
      ch      <= '0;
      idx     <= '0;
      o_sum   <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_ELEM; k++) begin
        taps[k] <= taps_nxt[k];
      end
      if (coef_wr_c) begin
        coef[i_coef_chan][i_coef_idx] <= i_coef_data;
      end
      o_busy  <= (state_nxt != ST_IDLE);
      o_valid <= (state_nxt == ST_DONE);

      if (state == ST_IDLE && i_start_calc) begin
        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
          snap[k] <= taps_nxt[k];
        end
        ch  <= '0;
        idx <= '0;
      end else if (state == ST_MAC) begin
        if (last_tap_c) begin
          stage[ch] <= acc_next_c;
          idx       <= '0;
          ch        <= ch + CHAN_W'(1);
          // Publish every channel at once so o_sum never mixes old and new results.
          if (last_chan_c) begin
            for (int unsigned c = 0; c < NUM_CHAN; c++) begin
              o_sum[sum_slice(c, ACC_BITS) +: ACC_BITS] <=
                (CHAN_W'(c) == ch) ? acc_next_c : stage[c];
            end
          end
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wavelet_fir_bank.sv
// Directed plus randomized bench for wavelet_fir_bank against an arithmetic reference model.
module tb_wavelet_fir_bank;

  localparam int B    = 8;
  localparam int N    = 7;
  localparam int C    = 4;
  localparam int ACC  = 2 * B + $clog2(N) + 1;
  localparam int LAT  = N * C;

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [B-1:0] i_sample;
  logic                i_sample_valid;
  logic                i_coef_we;
  logic [1:0]          i_coef_chan;
  logic [2:0]          i_coef_idx;
  logic signed [B-1:0] i_coef_data;
  logic                i_start_calc;
  logic                o_busy;
  logic                o_valid;
  logic [C*ACC-1:0]    o_sum;

  int checks   = 0;
  int failures = 0;

  int     coef_m [C][N];
  int     hist   [N];
  longint exp_sum[C];

  always #5 clk = ~clk;

  wavelet_fir_bank dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .i_coef_we      (i_coef_we),
    .i_coef_chan    (i_coef_chan),
    .i_coef_idx     (i_coef_idx),
    .i_coef_data    (i_coef_data),
    .i_start_calc   (i_start_calc),
    .o_busy         (o_busy),
    .o_valid        (o_valid),
    .o_sum          (o_sum)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sum_of(input int c);
    logic signed [ACC-1:0] s;
    s = o_sum[c*ACC +: ACC];
    return longint'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_sample       = '0;
    i_sample_valid = 1'b0;
    i_coef_we      = 1'b0;
    i_coef_chan    = '0;
    i_coef_idx     = '0;
    i_coef_data    = '0;
    i_start_calc   = 1'b0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < C; c++) for (int k = 0; k < N; k++) coef_m[c][k] = 0;
    for (int k = 0; k < N; k++) hist[k] = 0;
  endtask

  task automatic model_push(input int s);
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
  endtask

  task automatic write_coef(input int ch, input int idx, input logic signed [B-1:0] data);
    i_coef_we   = 1'b1;
    i_coef_chan = 2'(ch);
    i_coef_idx  = 3'(idx);
    i_coef_data = data;
    step();
    i_coef_we = 1'b0;
    if (idx < N) coef_m[ch][idx] = int'(data);
  endtask

  task automatic shift(input logic signed [B-1:0] s);
    i_sample       = s;
    i_sample_valid = 1'b1;
    step();
    i_sample_valid = 1'b0;
    model_push(int'(s));
  endtask

  // One computation: start, wait for o_valid within a bound, compare every channel.
  task automatic run_calc(input string tag, input bit shift_with_start,
                          input logic signed [B-1:0] s0, input bit noise,
                          input bit pokes, input bit busy_write);
    int lat;
    bit got;
    int extra;
    i_start_calc = 1'b1;
    if (shift_with_start) begin
      i_sample       = s0;
      i_sample_valid = 1'b1;
      model_push(int'(s0));
    end
    for (int c = 0; c < C; c++) begin
      exp_sum[c] = 0;
      for (int k = 0; k < N; k++) exp_sum[c] += longint'(coef_m[c][k]) * longint'(hist[k]);
    end
    step();
    i_start_calc   = 1'b0;
    i_sample_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < LAT + 12) begin
      if (o_valid) begin
        got = 1'b1;
      end else begin
        check({tag, "_busy_mac"}, longint'(o_busy), 1);
        if (noise && $urandom_range(0, 1) == 1) begin
          i_sample       = B'($urandom);
          i_sample_valid = 1'b1;
          model_push(int'(i_sample));
        end
        if (pokes && lat == 4) i_start_calc = 1'b1;
        if (busy_write && lat == 2) begin
          i_coef_we   = 1'b1;
          i_coef_chan = 2'd0;
          i_coef_idx  = 3'd0;
          i_coef_data = 8'sd55;
        end
        step();
        lat++;
        idle_inputs();
      end
    end
    check({tag, "_latency"}, longint'(lat), longint'(LAT));
    check({tag, "_busy_at_valid"}, longint'(o_busy), 1);
    for (int c = 0; c < C; c++) check({tag, "_sum"}, sum_of(c), exp_sum[c]);
    if (pokes) i_start_calc = 1'b1;
    step();
    i_start_calc = 1'b0;
    check({tag, "_valid_pulse"}, longint'(o_valid), 0);
    check({tag, "_busy_end"}, longint'(o_busy), 0);
    if (pokes) begin
      extra = 0;
      for (int t = 0; t < LAT + 6; t++) begin
        if (o_valid || o_busy) extra++;
        step();
      end
      check({tag, "_no_requeue"}, longint'(extra), 0);
      check({tag, "_sum_held"}, sum_of(0), exp_sum[0]);
    end
  endtask

  initial begin
    int extra;
    // Reset with random junk on the inputs.
    rst_n = 1'b0;
    for (int t = 0; t < 2; t++) begin
      i_sample       = B'($urandom);
      i_sample_valid = 1'($urandom);
      i_coef_we      = 1'($urandom);
      i_coef_chan    = 2'($urandom);
      i_coef_idx     = 3'($urandom);
      i_coef_data    = B'($urandom);
      i_start_calc   = 1'($urandom);
      step();
    end
    model_clear();
    check("reset_busy", longint'(o_busy), 0);
    check("reset_valid", longint'(o_valid), 0);
    for (int c = 0; c < C; c++) check("reset_sum", sum_of(c), 0);
    idle_inputs();
    rst_n = 1'b1;
    step();
    run_calc("zero", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Basic sums.
    for (int k = 0; k < N; k++) write_coef(0, k, 8'sd2);
    for (int k = 0; k < N; k++) write_coef(1, k, B'(k + 1));
    for (int k = 0; k < N; k++) shift(8'sd3);
    run_calc("basic", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("basic_sum0", sum_of(0), 42);
    check("basic_sum1", sum_of(1), 84);
    check("basic_sum2", sum_of(2), 0);
    check("basic_sum3", sum_of(3), 0);

    // Extremes.
    for (int c = 0; c < C; c++) for (int k = 0; k < N; k++) write_coef(c, k, -8'sd128);
    for (int k = 0; k < N; k++) shift(-8'sd128);
    run_calc("ext_neg", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < C; c++) check("ext_neg_lit", sum_of(c), 114688);
    for (int c = 0; c < C; c++) for (int k = 0; k < N; k++) write_coef(c, k, 8'sd127);
    run_calc("ext_mix", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("ext_mix_lit", sum_of(0), -113792);

    // Tap ordering.
    for (int k = 0; k < N; k++) write_coef(0, k, (k == 0) ? 8'sd1 : 8'sd0);
    shift(8'sd5);
    shift(8'sd9);
    run_calc("order0", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("order0_lit", sum_of(0), 9);
    write_coef(0, 0, 8'sd0);
    write_coef(0, 6, 8'sd1);
    for (int k = 1; k <= N; k++) shift(B'(k));
    run_calc("order6", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("order6_lit", sum_of(0), 1);

    // Handshake: ignored starts, dropped busy write, back-to-back acceptance.
    write_coef(0, 0, 8'sd1);
    run_calc("hs_poke", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    run_calc("hs_b2b_a", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    run_calc("hs_b2b_b", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    write_coef(0, 7, 8'sd99);
    run_calc("oor_idx", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Concurrency: same-cycle shift included, shifts during MAC excluded.
    for (int k = 0; k < N; k++) write_coef(0, k, (k == 0) ? 8'sd1 : 8'sd0);
    run_calc("conc", 1'b1, 8'sd77, 1'b1, 1'b0, 1'b0);
    check("conc_lit", sum_of(0), 77);

    // Randomized coefficient sets and sample streams.
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 10; w++) write_coef($urandom_range(0, C - 1), $urandom_range(0, 7), B'($urandom));
      for (int s = 0; s < $urandom_range(0, 8); s++) shift(B'($urandom));
      run_calc("rand", 1'($urandom), B'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    // Reset during MAC cycle 10 aborts and clears.
    i_start_calc = 1'b1;
    step();
    i_start_calc = 1'b0;
    for (int t = 1; t < 10; t++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    check("mid_rst_busy", longint'(o_busy), 0);
    check("mid_rst_valid", longint'(o_valid), 0);
    for (int c = 0; c < C; c++) check("mid_rst_sum", sum_of(c), 0);
    extra = 0;
    for (int t = 0; t < LAT + 4; t++) begin
      if (o_valid) extra++;
      step();
    end
    check("mid_rst_no_valid", longint'(extra), 0);
    for (int w = 0; w < 8; w++) write_coef($urandom_range(0, C - 1), $urandom_range(0, N - 1), B'($urandom));
    for (int s = 0; s < 4; s++) shift(B'($urandom));
    run_calc("post_rst", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
